// File: rtl/i2s_tx.sv
// I2S-style serial audio transmitter: double-buffered stereo input, 64-bit frames
// of two MSB-aligned 32-bit slots, left-justified, LRCK high = left, change on BCK fall.
module i2s_tx #(
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned BCK_DIV = 2
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              enable,
  input  logic              mute,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  output logic              frame_start,
  output logic              underrun,
  output logic              BCKO,
  output logic              LRCKO,
  output logic              DOUT
);

  localparam int unsigned      DIV_W    = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam int unsigned      PAD_W    = 32 - DATA_W;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STOPPING
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DIV_W-1:0]    r_div;
  logic                r_bck;
  logic                r_lrck;
  logic                r_dout;
  logic [5:0]          r_bit_cnt;
  logic [63:0]         r_shift;
  logic [DATA_W-1:0]   r_hold_l;
  logic [DATA_W-1:0]   r_hold_r;
  logic                r_hold_full;
  logic                r_frame_start;
  logic                r_underrun;

  logic                w_tc;
  logic                w_fall;
  logic                w_frame_end;
  logic                w_frame_load;
  logic                w_stop_done;
  logic                w_xfer;
  logic [5:0]          w_bit_nxt;
  logic [31:0]         w_slot_l;
  logic [31:0]         w_slot_r;
  logic [63:0]         w_word;

  // Frame timing is derived only from registered state, so in_ready has no input path.
  assign w_tc         = (r_state != ST_IDLE) && (r_div == DIV_LAST);
  assign w_fall       = w_tc && r_bck;
  assign w_frame_end  = w_fall && (r_bit_cnt == 6'd63);
  assign w_frame_load = w_frame_end && (r_state == ST_RUN);
  assign w_stop_done  = w_frame_end && (r_state == ST_STOPPING);
  assign w_bit_nxt    = r_bit_cnt + 6'd1;

  assign in_ready = ~r_hold_full | w_frame_load;
  assign w_xfer   = in_valid & in_ready;

  assign w_slot_l = 32'(r_hold_l) << PAD_W;
  assign w_slot_r = 32'(r_hold_r) << PAD_W;
  assign w_word   = (mute || !r_hold_full) ? 64'd0 : {w_slot_l, w_slot_r};

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // A stop always finishes the current frame before returning to idle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (enable) w_state_nxt = ST_RUN;
      ST_RUN:      if (!enable) w_state_nxt = ST_STOPPING;
      ST_STOPPING: begin
        if (w_stop_done)  w_state_nxt = ST_IDLE;
        else if (enable)  w_state_nxt = ST_RUN;
      end
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_hold_l    <= '0;
      r_hold_r    <= '0;
      r_hold_full <= 1'b0;
    end else if (w_xfer) begin
      r_hold_l    <= in_left;
      r_hold_r    <= in_right;
      r_hold_full <= 1'b1;
    end else if (w_frame_load) begin
      r_hold_full <= 1'b0;
    end
  end

  // Bit clock divider, frame counter and output shifter.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_div         <= '0;
      r_bck         <= 1'b0;
      r_lrck        <= 1'b0;
      r_dout        <= 1'b0;
      r_bit_cnt     <= 6'd63;
      r_shift       <= '0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      if (r_state == ST_IDLE || w_stop_done) begin
        r_div     <= '0;
        r_bck     <= 1'b0;
        r_lrck    <= 1'b0;
        r_dout    <= 1'b0;
        r_bit_cnt <= 6'd63;
        r_shift   <= '0;
      end else begin
        r_div <= w_tc ? '0 : r_div + DIV_W'(1);
        if (w_tc) r_bck <= ~r_bck;
        if (w_fall) begin
          r_bit_cnt <= w_bit_nxt;
          r_lrck    <= ~w_bit_nxt[5];
          if (w_frame_load) begin
            r_dout        <= w_word[63];
            r_shift       <= {w_word[62:0], 1'b0};
            r_frame_start <= 1'b1;
            r_underrun    <= ~r_hold_full & ~mute;
          end else begin
            r_dout  <= r_shift[63];
            r_shift <= {r_shift[62:0], 1'b0};
          end
        end
      end
    end
  end

  assign frame_start = r_frame_start;
  assign underrun    = r_underrun;
  assign BCKO        = r_bck;
  assign LRCKO       = r_lrck;
  assign DOUT        = r_dout;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: a scoreboard of expected frame words, filled on each input
// transfer and drained at each frame load, plus directed timing sequences.
module tb_i2s_tx;
  localparam int unsigned DATA_W  = 24;
  localparam int unsigned BCK_DIV = 2;

  logic              clk = 1'b0;
  logic              nRST;
  logic              enable;
  logic              mute;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_left;
  logic [DATA_W-1:0] in_right;
  logic              frame_start;
  logic              underrun;
  logic              BCKO;
  logic              LRCKO;
  logic              DOUT;

  i2s_tx #(.DATA_W(DATA_W), .BCK_DIV(BCK_DIV)) dut (
    .clk(clk), .nRST(nRST), .enable(enable), .mute(mute),
    .in_valid(in_valid), .in_ready(in_ready), .in_left(in_left), .in_right(in_right),
    .frame_start(frame_start), .underrun(underrun),
    .BCKO(BCKO), .LRCKO(LRCKO), .DOUT(DOUT)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_word(input logic [23:0] l, input logic [23:0] r);
    return {l, 8'h00, r, 8'h00};
  endfunction

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [63:0] exp;
  } vec_t;
  vec_t tab [8];

  // Scoreboard and frame monitor state
  logic [63:0] sb [$];
  logic [63:0] cur_exp = '0;
  logic [63:0] pend_e, got, fexp, e;
  logic        pend_v = 1'b0, prev_bck = 1'b0, prev_mute = 1'b0, in_frame = 1'b0, exp_u;
  logic        bp_phase = 1'b0;
  int          bit_idx = 0, lrck_bad = 0, frames_done = 0, xfer_since = 0, bp_fs = 0;

  // Pops at frame load before committing a transfer made on that same edge.
  always @(negedge clk) begin
    if (!nRST) begin
      sb.delete();
      in_frame = 1'b0;
      pend_v   = 1'b0;
      prev_bck = 1'b0;
    end else begin
      if (frame_start) begin
        if (in_frame) chk("frame_short", 64'(bit_idx), 64'd64);
        if (sb.size() == 0) begin
          fexp  = '0;
          exp_u = !prev_mute;
        end else begin
          e     = sb.pop_front();
          fexp  = prev_mute ? 64'd0 : e;
          exp_u = 1'b0;
        end
        chk("underrun_flag", 64'(underrun), 64'(exp_u));
        if (bp_phase) begin
          bp_fs++;
          if (bp_fs > 2) chk("bp_one_xfer", 64'(xfer_since), 64'd1);
        end
        xfer_since = 0;
        in_frame   = 1'b1;
        bit_idx    = 0;
        lrck_bad   = 0;
        got        = '0;
      end
      if (BCKO && !prev_bck && in_frame) begin
        if (LRCKO !== (bit_idx < 32)) lrck_bad++;
        got[63-bit_idx] = DOUT;
        bit_idx++;
        if (bit_idx == 64) begin
          chk("frame_data", got, fexp);
          chk("lrck_slot", 64'(lrck_bad), 64'd0);
          in_frame = 1'b0;
          frames_done++;
        end
      end
      if (pend_v) begin
        sb.push_back(pend_e);
        xfer_since++;
      end
      pend_v    = in_valid && in_ready;
      pend_e    = cur_exp;
      prev_bck  = BCKO;
      prev_mute = mute;
    end
  end

  task automatic push_pair(input logic [23:0] l, input logic [23:0] r,
                           input logic [63:0] ex, input bit keep_valid);
    bit ok = 1'b0;
    in_left  = l;
    in_right = r;
    cur_exp  = ex;
    in_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("xfer_timeout", 64'(ok), 64'd1);
    @(posedge clk); #1;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic wait_fs(input int lim, output int k);
    k = 0;
    for (int i = 1; i <= lim; i++) begin
      @(posedge clk); #1;
      if (frame_start) begin
        k = i;
        break;
      end
    end
    if (k == 0) chk("fs_timeout", 64'(k), 64'(lim));
  endtask

  task automatic wait_falls(input int n);
    int   c  = 0;
    logic pb = BCKO;
    for (int i = 0; i < n * 4 * BCK_DIV + 10 && c < n; i++) begin
      @(posedge clk); #1;
      if (pb && !BCKO) c++;
      pb = BCKO;
    end
    if (c < n) chk("falls_timeout", 64'(c), 64'(n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    int k, bad, fd0;
    tab[0] = '{24'h000001, 24'h800000, 64'h00000100_80000000};
    tab[1] = '{24'hFFFFFF, 24'h000000, 64'hFFFFFF00_00000000};
    tab[2] = '{24'h000000, 24'hFFFFFF, 64'h00000000_FFFFFF00};
    tab[3] = '{24'h5A5A5A, 24'hA5A5A5, 64'h5A5A5A00_A5A5A500};
    tab[4] = '{24'h123456, 24'h789ABC, 64'h12345600_789ABC00};
    tab[5] = '{24'h800001, 24'h7FFFFE, 64'h80000100_7FFFFE00};
    tab[6] = '{24'hC0FFEE, 24'hDEADBE, 64'hC0FFEE00_DEADBE00};
    tab[7] = '{24'h0F0F0F, 24'hF0F0F0, 64'h0F0F0F00_F0F0F000};

    // Reset with enable and valid asserted
    nRST = 1'b0; enable = 1'b1; mute = 1'b0; in_valid = 1'b1;
    in_left = 24'h111111; in_right = 24'h222222;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_bcko", 64'(BCKO), 64'd0);
    chk("reset_lrcko", 64'(LRCKO), 64'd0);
    chk("reset_dout", 64'(DOUT), 64'd0);
    chk("reset_ready", 64'(in_ready), 64'd1);
    chk("reset_fs", 64'(frame_start), 64'd0);
    chk("reset_underrun", 64'(underrun), 64'd0);
    enable = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    nRST = 1'b1;
    bad = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (BCKO || LRCKO || DOUT || frame_start || underrun) bad++;
    end
    chk("idle_pins", 64'(bad), 64'd0);

    // Single frame, first-fall latency and period
    push_pair(24'hA5C3F1, 24'h123456, 64'hA5C3F100_12345600, 1'b0);
    enable = 1'b1;
    wait_fs(20, k);
    chk("first_fall_lat", 64'(k - 1), 64'(2 * BCK_DIV));
    chk("first_lrck", 64'(LRCKO), 64'd1);
    chk("first_dout_msb", 64'(DOUT), 64'd1);
    chk("first_bck_low", 64'(BCKO), 64'd0);
    wait_fs(300, k);
    chk("frame_period", 64'(k), 64'd256);
    chk("underrun_pulse", 64'(underrun), 64'd1);
    repeat (50) begin
      @(posedge clk); #1;
    end
    push_pair(24'h00FF00, 24'hFF00FF, mk_word(24'h00FF00, 24'hFF00FF), 1'b0);
    wait_fs(300, k);
    chk("refill_no_underrun", 64'(underrun), 64'd0);

    // Back-pressure: valid held high, one transfer per frame
    bp_phase = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_pair(tab[i].l, tab[i].r, tab[i].exp, 1'b1);
      chk("bp_ready_low", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    bp_phase = 1'b0;
    wait_fs(300, k);
    wait_fs(300, k);

    // Mute consumes the holding register without underrun
    push_pair(24'hABCDEF, 24'h654321, mk_word(24'hABCDEF, 24'h654321), 1'b0);
    mute = 1'b1;
    wait_fs(300, k);
    chk("mute_no_underrun", 64'(underrun), 64'd0);
    chk("mute_consumed", 64'(in_ready), 64'd1);
    mute = 1'b0;
    push_pair(24'h3C3C3C, 24'h0000FF, mk_word(24'h3C3C3C, 24'h0000FF), 1'b0);
    wait_fs(300, k);

    // Stop at bit 10: frame completes, then pins idle
    wait_falls(10);
    enable = 1'b0;
    fd0 = frames_done;
    for (int i = 0; i < 400 && frames_done == fd0; i++) begin
      @(posedge clk); #1;
    end
    chk("stop_completes", 64'(frames_done), 64'(fd0 + 1));
    repeat (2 * BCK_DIV + 1) @(posedge clk);
    #1;
    bad = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (BCKO || LRCKO || DOUT || frame_start) bad++;
    end
    chk("stop_idle_pins", 64'(bad), 64'd0);

    // Async reset at bit 40 with holding full
    enable = 1'b1;
    push_pair(24'h0F0F0F, 24'hFFFFFF, mk_word(24'h0F0F0F, 24'hFFFFFF), 1'b0);
    wait_fs(400, k);
    push_pair(24'h777777, 24'h888888, mk_word(24'h777777, 24'h888888), 1'b0);
    wait_falls(40);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_reset_bck", 64'(BCKO), 64'd1);
    chk("pre_reset_dout", 64'(DOUT), 64'd1);
    chk("pre_reset_ready", 64'(in_ready), 64'd0);
    #2;
    nRST = 1'b0;
    #1;
    chk("abort_bcko", 64'(BCKO), 64'd0);
    chk("abort_lrcko", 64'(LRCKO), 64'd0);
    chk("abort_dout", 64'(DOUT), 64'd0);
    chk("abort_ready", 64'(in_ready), 64'd1);
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nRST = 1'b1;
    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
